// File: rtl/telemetry_pkg.sv
// telemetry_pkg: shared state encoding, sync defaults and frame-length helper for the telemetry framer.
package telemetry_pkg;
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, WAIT} tlm_state_t;
    localparam logic [7:0] DEF_SYNC0 = 8'hAA;
    localparam logic [7:0] DEF_SYNC1 = 8'h55;
    function automatic int frame_len(int width);
        return width / 8 + 3;
    endfunction
endpackage

// File: rtl/telemetry_frame_tx_if.sv
// telemetry_frame_tx_if: FIFO read port and uart_tx start/done handshake seen by the framer.
interface telemetry_frame_tx_if #(parameter int W = 224);
    logic         fifo_empty;
    logic [W-1:0] fifo_rd_data;
    logic         fifo_rd_en;
    logic         uart_tx_done;
    logic         uart_start_tx;
    logic [7:0]   uart_tx_din;
    modport master(input fifo_empty, fifo_rd_data, uart_tx_done, output fifo_rd_en, uart_start_tx, uart_tx_din);
    modport slave(output fifo_empty, fifo_rd_data, uart_tx_done, input fifo_rd_en, uart_start_tx, uart_tx_din);
endinterface

// File: rtl/telemetry_frame_tx_byte_sel.sv
// frame_byte_sel: picks the frame byte for a given index (sync pair, payload MSB byte first, checksum).
module frame_byte_sel import telemetry_pkg::*; #(
    parameter int         W     = 224,
    parameter logic [7:0] SYNC0 = DEF_SYNC0,
    parameter logic [7:0] SYNC1 = DEF_SYNC1,
    parameter int         IW    = 5
) (
    input  logic [W-1:0]  payload,
    input  logic [IW-1:0] idx,
    input  logic [7:0]    csum,
    output logic [7:0]    byte_o
);
    localparam int PW = $clog2(W);
    logic [PW-1:0] base;
    // base is meaningless for sync/checksum indices; the select below never uses it then
    assign base   = PW'(W - 1) - PW'({idx - IW'(2), 3'b000});
    assign byte_o = idx == '0 ? SYNC0 :
                    idx == IW'(1) ? SYNC1 :
                    idx == IW'(W / 8 + 2) ? -csum :
                    payload[base -: 8];
endmodule

// File: rtl/telemetry_frame_tx.sv
// telemetry_frame_tx: pops 224-bit telemetry words and streams them to uart_tx as
// SYNC0, SYNC1, payload bytes (MSB first), two's-complement checksum.
module telemetry_frame_tx import telemetry_pkg::*; #(
    parameter int         FIFO_RD_DATA_WIDTH = 224,
    parameter logic [7:0] SYNC0              = DEF_SYNC0,
    parameter logic [7:0] SYNC1              = DEF_SYNC1,
    parameter int         CNT_WIDTH          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fsm_en,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count,
    telemetry_frame_tx_if.master bus
);
    localparam int W = FIFO_RD_DATA_WIDTH;
    localparam int NB = W / 8;
    localparam int IW = $clog2(frame_len(W));
    localparam logic [IW-1:0] LAST = IW'(NB + 2);

    if (W % 8 != 0) begin : g_width_check
        $error("FIFO_RD_DATA_WIDTH must be a multiple of 8");
    end

    tlm_state_t           state_q, state_d;
    logic [W-1:0]         payload_q, payload_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rd_en_q, rd_en_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic [7:0]           din_q, din_d;
    logic [7:0]           sel_byte;

    // Selector sees next-cycle values so the byte is registered alongside its start pulse
    frame_byte_sel #(.W(W), .SYNC0(SYNC0), .SYNC1(SYNC1), .IW(IW)) u_sel (
        .payload(payload_d),
        .idx(idx_d),
        .csum(csum_d),
        .byte_o(sel_byte)
    );

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE:  state_d = fsm_en && !bus.fifo_empty ? POP : IDLE;
            POP:   state_d = LOAD;
            LOAD: begin
                payload_d = bus.fifo_rd_data;
                idx_d     = '0;
                csum_d    = '0;
                state_d   = START;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.uart_tx_done && idx_q == LAST) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end else if (bus.uart_tx_done) begin
                    // Only payload bytes (idx 2..NB+1) feed the checksum
                    csum_d  = idx_q >= IW'(2) ? csum_q + din_q : csum_q;
                    idx_d   = idx_q + 1'b1;
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_en_d = state_d == POP;
        start_d = state_d == START;
        busy_d  = state_d != IDLE;
        din_d   = start_d ? sel_byte : din_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            payload_q <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            cnt_q     <= cnt_d;
            rd_en_q   <= rd_en_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            din_q     <= din_d;
        end
    end

    assign bus.fifo_rd_en    = rd_en_q;
    assign bus.uart_start_tx = start_q;
    assign bus.uart_tx_din   = din_q;
    assign busy              = busy_q;
    assign frame_count       = cnt_q;
endmodule

// File: tb/tb_telemetry_frame_tx.sv
// tb_telemetry_frame_tx: FIFO and uart_tx models drive the framer; a byte-queue reference
// built from each popped word checks every transmitted byte, timing and counters.
module tb_telemetry_frame_tx;
    import telemetry_pkg::*;
    localparam int W = 224;
    localparam int NB = W / 8;
    localparam int FL = frame_len(W);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fsm_en = 1'b0;
    logic        busy;
    logic [15:0] frame_count;

    telemetry_frame_tx_if #(.W(W)) bus();

    telemetry_frame_tx #(.FIFO_RD_DATA_WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .fsm_en(fsm_en),
        .busy(busy),
        .frame_count(frame_count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] fifo_q[$];
    logic [7:0]   exp_q[$];
    int           cyc = 0, n_rd = 0, n_start = 0, exp_frames = 0, rx_idx = 0;
    int           rd_cyc = 0, lat = -1, tmr = 0, dly = 20, long_at = -1;
    logic [7:0]   rx_sum = 0, held = 0, first_byte = 0, last_byte = 0;
    bit           pending = 0, hold_bad = 0, spur_idle = 0, spur_start = 0;

    // Reference frame: sync pair, payload bytes high to low, then byte making the payload sum zero
    task automatic push_exp(input logic [W-1:0] w);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'd0;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        for (int k = NB - 1; k >= 0; k--) begin
            b = w[8*k +: 8];
            exp_q.push_back(b);
            s = s + b;
        end
        exp_q.push_back(8'd0 - s);
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    initial begin
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
        bus.uart_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.uart_tx_done = 1'b0;
            if (reset) begin
                exp_q.delete();
                pending    = 0;
                rx_idx     = 0;
                rx_sum     = 0;
                exp_frames = 0;
            end else begin
                if (bus.fifo_rd_en) begin
                    chk("rd_en_nonempty", fifo_q.size() != 0, 1);
                    n_rd++;
                    rd_cyc = cyc;
                    if (fifo_q.size() != 0) begin
                        bus.fifo_rd_data = fifo_q.pop_front();
                        push_exp(bus.fifo_rd_data);
                    end
                end
                if (bus.uart_start_tx) begin
                    chk("one_start_per_done", pending, 0);
                    chk("start_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("frame_byte", bus.uart_tx_din, exp_q.pop_front());
                    if (rx_idx == 0) begin
                        lat        = cyc - rd_cyc;
                        first_byte = bus.uart_tx_din;
                    end
                    if (rx_idx == FL - 1) chk("csum_prop", 8'(rx_sum + bus.uart_tx_din), 0);
                    else if (rx_idx >= 2) rx_sum = rx_sum + bus.uart_tx_din;
                    last_byte = bus.uart_tx_din;
                    held      = bus.uart_tx_din;
                    hold_bad  = 0;
                    pending   = 1;
                    tmr       = rx_idx == long_at ? 5000 : dly;
                    rx_idx++;
                    n_start++;
                    if (spur_start) bus.uart_tx_done = 1'b1;
                end else if (pending) begin
                    if (bus.uart_tx_din !== held) hold_bad = 1;
                    tmr--;
                    if (tmr == 0) begin
                        chk("din_hold", hold_bad, 0);
                        bus.uart_tx_done = 1'b1;
                        pending = 0;
                        if (rx_idx == FL) begin
                            exp_frames++;
                            rx_idx = 0;
                            rx_sum = 0;
                        end
                    end
                end else if (spur_idle) begin
                    bus.uart_tx_done = 1'b1;
                end
            end
            bus.fifo_empty = fifo_q.size() == 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (!busy && !pending && fifo_q.size() == 0 && exp_q.size() == 0 && rx_idx == 0) break;
        end
        chk(tag, i < budget, 1);
        repeat (3) tick();
    endtask

    task automatic wait_rx(input string tag, input int n);
        int i;
        for (i = 0; i < 4000 && rx_idx != n; i++) tick();
        chk(tag, rx_idx, n);
    endtask

    initial begin
        logic [W-1:0] w;
        int s_rd, s_st, f0;
        bit busy_seen;
        repeat (3) tick();
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_start", bus.uart_start_tx, 0);
        chk("rst_din", bus.uart_tx_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", frame_count, 0);
        reset = 1'b0;
        tick();

        // Known payload 01..1C; checksum byte is -(406 mod 256) = 8'h6A
        for (int k = 0; k < NB; k++) w[W-1-8*k -: 8] = 8'(k + 1);
        fsm_en = 1'b1;
        fifo_q.push_back(w);
        wait_idle("t1_timeout", 3000);
        chk("t1_starts", n_start, FL);
        chk("t1_latency", lat, 2);
        chk("t1_csum", last_byte, 8'h6A);
        chk("t1_count", frame_count, 1);

        s_rd = n_rd;
        s_st = n_start;
        busy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (busy) busy_seen = 1;
        end
        chk("t2_rd", n_rd - s_rd, 0);
        chk("t2_start", n_start - s_st, 0);
        chk("t2_busy", busy_seen, 0);

        s_rd = n_rd;
        fifo_q.push_back(rnd_word());
        fifo_q.push_back(rnd_word());
        wait_idle("t3_timeout", 4000);
        chk("t3_rd", n_rd - s_rd, 2);
        chk("t3_count", frame_count, 3);

        s_rd = n_rd;
        f0 = exp_frames;
        fifo_q.push_back(rnd_word());
        fifo_q.push_back(rnd_word());
        wait_rx("t4_reach5", 5);
        fsm_en = 1'b0;
        for (int i = 0; i < 4000 && exp_frames == f0; i++) tick();
        repeat (200) tick();
        chk("t4_frames", exp_frames, f0 + 1);
        chk("t4_rd", n_rd - s_rd, 1);
        chk("t4_left", fifo_q.size(), 1);
        chk("t4_busy", busy, 0);
        fsm_en = 1'b1;
        wait_idle("t4_timeout", 3000);
        chk("t4_count", frame_count, exp_frames);

        fifo_q.push_back(rnd_word());
        fifo_q.push_back(rnd_word());
        wait_rx("t5_reach10", 10);
        repeat (3) tick();
        @(posedge clk);
        #2 reset = 1'b1;
        tick();
        chk("t5_rd_en", bus.fifo_rd_en, 0);
        chk("t5_start", bus.uart_start_tx, 0);
        chk("t5_din", bus.uart_tx_din, 0);
        chk("t5_busy", busy, 0);
        chk("t5_count_rst", frame_count, 0);
        chk("t5_state", dut.state_q, IDLE);
        tick();
        reset = 1'b0;
        wait_idle("t5_timeout", 3000);
        chk("t5_first", first_byte, 8'hAA);
        chk("t5_count", frame_count, 1);

        fsm_en = 1'b0;
        s_st = n_start;
        spur_idle = 1;
        repeat (50) tick();
        spur_idle = 0;
        chk("t6_idle_start", n_start - s_st, 0);
        chk("t6_idle_count", frame_count, 1);
        long_at = 3;
        spur_start = 1;
        fsm_en = 1'b1;
        fifo_q.push_back(rnd_word());
        wait_idle("t6_timeout", 12000);
        long_at = -1;
        spur_start = 0;
        chk("t6_count", frame_count, exp_frames);

        for (int r = 0; r < 8; r++) begin
            dly = $urandom_range(1, 25);
            fifo_q.push_back(rnd_word());
            if ($urandom_range(0, 1) == 1) fifo_q.push_back(rnd_word());
            wait_idle("t7_timeout", 5000);
            chk("t7_count", frame_count, exp_frames);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
